// File: rtl/task_1_output.sv
// task_1_output: buffers one packet from the input stage, appends an XOR checksum trailer
//   and replays it on an AXI-Stream-style master port (tlast on the trailer beat).
// Ports: i_clk/i_rst (sync, active-high); i_data/i_enb/i_src_empty from the input stage;
//   i_m_tready, o_m_tdata/o_m_tvalid/o_m_tlast downstream; o_output_last pulses after the
//   trailer handshake; o_busy, o_overflow (sticky drop flag), o_byte_count status.
module task_1_output #(
  parameter int         DEPTH    = 256,
  parameter int         CNT_W    = $clog2(DEPTH + 1),
  parameter logic [7:0] CHK_INIT = 8'h00
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_enb,
  input  logic             i_src_empty,
  input  logic             i_m_tready,
  output logic [7:0]       o_m_tdata,
  output logic             o_m_tvalid,
  output logic             o_m_tlast,
  output logic             o_output_last,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_byte_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    s_IDLE,
    s_COLLECT,
    s_SEND,
    s_TRAILER,
    s_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [DEPTH];
  // r_count doubles as the write pointer: bytes are stored densely from address 0.
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_rd;
  logic [7:0]       r_chk;
  logic             r_ovf;
  logic             r_busy;
  logic             w_store;
  logic             w_drop;
  logic             w_hs;
  logic             w_rd_last;

  assign w_rd_last = (r_rd == r_count - CNT_W'(1));
  assign w_hs      = o_m_tvalid & i_m_tready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= s_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs decode from the state only, so tvalid/tdata/tlast hold steady across stalls
  // and never depend combinationally on tready.
  always_comb begin
    w_state_nxt   = r_state;
    o_m_tvalid    = 1'b0;
    o_m_tdata     = 8'h00;
    o_m_tlast     = 1'b0;
    o_output_last = 1'b0;
    w_store       = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      s_IDLE: begin
        if (i_enb) begin
          w_store     = 1'b1;
          w_state_nxt = s_COLLECT;
        end
      end
      s_COLLECT: begin
        if (i_enb) begin
          if (r_count < CNT_W'(DEPTH)) begin
            w_store = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (i_src_empty) begin
          w_state_nxt = s_SEND;
        end
      end
      s_SEND: begin
        o_m_tvalid = 1'b1;
        o_m_tdata  = r_mem[r_rd[AW-1:0]];
        w_drop     = i_enb;
        if (i_m_tready && w_rd_last) begin
          w_state_nxt = s_TRAILER;
        end
      end
      s_TRAILER: begin
        o_m_tvalid = 1'b1;
        o_m_tdata  = r_chk;
        o_m_tlast  = 1'b1;
        w_drop     = i_enb;
        if (i_m_tready) begin
          w_state_nxt = s_DONE;
        end
      end
      s_DONE: begin
        o_output_last = 1'b1;
        w_drop        = i_enb;
        w_state_nxt   = s_IDLE;
      end
      default: begin
        w_state_nxt = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_rd    <= '0;
      r_chk   <= CHK_INIT;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != s_IDLE);
      case (r_state)
        s_IDLE: begin
          if (i_enb) begin
            r_count <= CNT_W'(1);
            r_rd    <= '0;
            r_chk   <= CHK_INIT ^ i_data;
            r_ovf   <= 1'b0;
          end
        end
        s_COLLECT: begin
          if (w_store) begin
            r_count <= r_count + CNT_W'(1);
            r_chk   <= r_chk ^ i_data;
          end
        end
        s_SEND: begin
          if (w_hs) begin
            r_rd <= r_rd + CNT_W'(1);
          end
        end
        s_DONE: begin
          r_count <= '0;
          r_rd    <= '0;
          r_chk   <= CHK_INIT;
        end
        default: begin
        end
      endcase
      // Any discarded byte (buffer full or arriving outside collection) is sticky until
      // the first byte of the next packet.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; contents are only read below the stored count.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem[r_count[AW-1:0]] <= i_data;
    end
  end

  assign o_busy       = r_busy;
  assign o_overflow   = r_ovf;
  assign o_byte_count = r_count;

endmodule

// File: doc/task_1_output.md
Name: task_1_output

Overview:
- Downstream neighbour of the task_1 input stage.
- Consumes the byte stream that stage drains from its FIFO (data plus enable qualifier), buffers one packet, and appends an XOR checksum trailer byte.
- Emits the packet on an AXI-Stream-style master interface with tlast on the trailer.
- Pulses o_output_last when the trailer is accepted, which tells the input stage to request the next packet.

Parameters:
- DEPTH, 256, maximum payload bytes stored per packet.
- CNT_W, $clog2(DEPTH+1), width of the byte counter.
- CHK_INIT, 8'h00, initial value of the XOR checksum accumulator.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  8  payload byte from the input stage; valid only when i_enb=1.
- i_enb  in  1  byte qualifier; one byte per cycle while high.
- i_src_empty  in  1  input-stage FIFO empty flag; used for end-of-packet detection.
- i_m_tready  in  1  downstream ready.
- o_m_tdata  out  8  output byte.
- o_m_tvalid  out  1  output valid.
- o_m_tlast  out  1  high on the checksum trailer beat only.
- o_output_last  out  1  one-cycle pulse after the trailer handshake; feeds the input stage's i_output_last.
- o_busy  out  1  high in every state except s_IDLE.
- o_overflow  out  1  sticky: a byte was dropped in the current or last packet.
- o_byte_count  out  CNT_W  number of payload bytes stored for the current packet.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=s_IDLE; write pointer, read pointer and byte count = 0; checksum=CHK_INIT.
  - All outputs 0. Buffer contents are don't-care.
  - Reset mid-operation abandons the packet immediately. No o_output_last is pulsed.
- States: s_IDLE, s_COLLECT, s_SEND, s_TRAILER, s_DONE.
- s_IDLE:
  - i_enb=1 -> store i_data at address 0; count=1; checksum=CHK_INIT^i_data; o_overflow cleared; next s_COLLECT.
  - Otherwise stay in s_IDLE.
- s_COLLECT:
  - Each cycle with i_enb=1 and count<DEPTH -> store the byte at address count; count+1; checksum ^= byte.
  - i_enb=1 with count==DEPTH -> drop the byte; set o_overflow; count and checksum are unchanged.
  - End of packet = a cycle with i_enb=0 and i_src_empty=1 -> next s_SEND.
  - i_enb=0 with i_src_empty=0 is an upstream gap -> stay in s_COLLECT.
- s_SEND:
  - o_m_tvalid=1, o_m_tdata=mem[rd], o_m_tlast=0.
  - On a handshake (tvalid & tready), rd+1.
  - Handshake with rd==count-1 -> next s_TRAILER.
- s_TRAILER:
  - o_m_tvalid=1, o_m_tdata=checksum, o_m_tlast=1.
  - Handshake -> next s_DONE.
- s_DONE:
  - o_output_last=1 for exactly this cycle.
  - rd, wr and count cleared; checksum=CHK_INIT.
  - Next s_IDLE. o_overflow is held.
- AXI rules:
  - Once o_m_tvalid rises, it stays high and o_m_tdata/o_m_tlast stay stable until a handshake.
  - o_m_tvalid never depends combinationally on i_m_tready.
  - Back-to-back beats are allowed: 1 beat per cycle when tready is held at 1.
- Latency:
  - End-detect cycle N -> first o_m_tvalid at N+1.
  - Packet of L bytes with tready=1 throughout -> L+1 valid beats, then o_output_last pulse on the following cycle.
- i_enb=1 in s_SEND, s_TRAILER or s_DONE is a protocol violation: the byte is discarded and o_overflow is set.
- o_busy is a registered decode of the state, high in s_COLLECT through s_DONE.
- o_byte_count holds the stored count from s_COLLECT until s_DONE, then reads 0.
- Packet length is always >=1: s_COLLECT is only entered with a byte.

Test Plan:
- Basic packet: bytes 8'h11, 8'h22, 8'h33 on consecutive i_enb cycles, then i_enb=0 with i_src_empty=1, tready=1.
  -> beats 11, 22, 33, 00 (checksum, tlast=1) on 4 consecutive cycles; o_output_last pulses 1 cycle later; o_byte_count=3 during send.
- Backpressure: same packet with tready toggling 1,0,0,1,...
  -> tdata/tlast stable while stalled; every byte appears exactly once; trailer=8'h00.
- Upstream gap: bytes A5 and 5A separated by 3 cycles of i_enb=0, i_src_empty=0.
  -> single packet: A5, 5A, then trailer FF with tlast.
- Overflow with DEPTH=4: 6 bytes 01..06.
  -> beats 01, 02, 03, 04, trailer 04; o_overflow=1; o_overflow clears on the first byte of the next packet.
- Reset in s_SEND after 1 beat:
  -> the next cycle shows tvalid=0, busy=0, o_output_last=0; a new 1-byte packet 7E then yields 7E and trailer 7E.
- Violation: i_enb=1 with byte 99 during s_TRAILER.
  -> byte is not emitted; o_overflow=1; o_output_last still pulses once.
